// File: rtl/mult8_sequencer.sv
// mult8_sequencer: 8x8 unsigned multiplier built from four passes through an
// external combinational 4x4 array multiplier (mul_a/mul_b out, mul_p back).
// Valid/ready on both the operand side and the product side.
// Optional feature: define MULT8_ZERO_SKIP_EN to bypass the four passes when
// either operand is zero at acceptance (result 0 is presented immediately).
`timescale 1ns/1ps

module mult8_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] product_q, product_d;

    logic        accept;
    logic        zero_skip;
    logic [15:0] pass_term;

    assign accept = in_valid && (state_q == IDLE);

`ifdef MULT8_ZERO_SKIP_EN
    // A zero operand makes the result known at acceptance, so skip the passes.
    assign zero_skip = (a == 8'd0) || (b == 8'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // Nibble selection for the external multiplier; quiet (0) outside MUL.
    // pass bit0 picks the A nibble, pass bit1 picks the B nibble.
    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (state_q == MUL) begin
            mul_a = pass_q[0] ? a_q[7:4] : a_q[3:0];
            mul_b = pass_q[1] ? b_q[7:4] : b_q[3:0];
        end
    end

    // Align the 4x4 partial product: weight is 4 bits per high nibble used.
    always_comb begin
        pass_term = 16'd0;
        case (pass_q)
            2'd0:    pass_term = {8'd0, mul_p};
            2'd1:    pass_term = {4'd0, mul_p, 4'd0};
            2'd2:    pass_term = {4'd0, mul_p, 4'd0};
            default: pass_term = {mul_p, 8'd0};
        endcase
    end

    // Next-state, operand capture and accumulation.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d       = a;
                    b_d       = b;
                    pass_d    = 2'd0;
                    product_d = 16'd0;
                    state_d   = zero_skip ? DONE : MUL;
                end
            end
            MUL: begin
                // Sum of all four terms tops out at 0xFE01, so no carry-out.
                product_d = product_q + pass_term;
                pass_d    = pass_q + 2'd1;
                if (pass_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Product is held (and kept after the handshake) until the
                // next acceptance clears it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pass_q    <= 2'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_mult8_sequencer.sv
// Self-checking bench for mult8_sequencer. The bench plays the external 4x4
// multiplier and keeps a transaction-level model (operands, passes done,
// retained result) that predicts every output on every falling edge.
`timescale 1ns/1ps

module tb_mult8_sequencer;

`ifdef MULT8_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    // Edges after the acceptance edge before out_valid shows up.
    localparam int LAT_FULL = 4;
    localparam int LAT_ZERO = SKIP ? 0 : 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] product;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;

    mult8_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    // External combinational 4x4 array multiplier.
    assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction model.
    bit          m_busy = 1'b0;
    logic [7:0]  m_a = 8'd0;
    logic [7:0]  m_b = 8'd0;
    int          m_n = 0;
    int          m_l = 4;
    logic [15:0] m_ret = 16'd0;

    // Observations for directed checks.
    int          since_acc = 0;
    int          lat_obs = -1;
    bit          acc_flag = 1'b0;
    logic [7:0]  mul_log[$];
    logic [15:0] hs_q[$];
    int          acc_q[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Running sum of the first n nibble products, in pass order
    // A.lo*B.lo, A.hi*B.lo, A.lo*B.hi, A.hi*B.hi.
    function automatic logic [15:0] partial(input logic [7:0] x, input logic [7:0] y, input int n);
        logic [15:0] s;
        logic [3:0]  p;
        logic [3:0]  q;
        s = 16'd0;
        for (int i = 0; i < n; i++) begin
            p = ((i % 2) == 1) ? x[7:4] : x[3:0];
            q = (i >= 2) ? y[7:4] : y[3:0];
            s = s + (16'(p) * 16'(q) << (4 * ((i % 2) + (i / 2))));
        end
        return s;
    endfunction

    // Compare all outputs against the model, then advance the model using the
    // inputs that the coming rising edge will sample.
    function automatic void cmp_adv();
        logic        e_ir;
        logic        e_busy;
        logic        e_ov;
        logic [15:0] e_prod;
        logic [3:0]  e_ma;
        logic [3:0]  e_mb;
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_product", 32'(product), 32'd0);
            chk("rst_mul_a", 32'(mul_a), 32'd0);
            chk("rst_mul_b", 32'(mul_b), 32'd0);
            m_busy = 1'b0;
            m_ret  = 16'd0;
            m_n    = 0;
            return;
        end
        since_acc++;
        e_ir   = !m_busy;
        e_busy = m_busy;
        e_ov   = 1'b0;
        e_prod = m_ret;
        e_ma   = 4'd0;
        e_mb   = 4'd0;
        if (m_busy && m_n < m_l) begin
            e_prod = partial(m_a, m_b, m_n);
            e_ma   = ((m_n % 2) == 1) ? m_a[7:4] : m_a[3:0];
            e_mb   = (m_n >= 2) ? m_b[7:4] : m_b[3:0];
        end else if (m_busy) begin
            e_ov   = 1'b1;
            e_prod = {8'd0, m_a} * {8'd0, m_b};
        end
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("product", 32'(product), 32'(e_prod));
        chk("mul_a", 32'(mul_a), 32'(e_ma));
        chk("mul_b", 32'(mul_b), 32'(e_mb));

        if (out_valid && lat_obs < 0) lat_obs = since_acc;
        if (busy && !out_valid) mul_log.push_back({mul_a, mul_b});

        if (!m_busy) begin
            if (in_valid) begin
                m_busy    = 1'b1;
                m_a       = a;
                m_b       = b;
                m_n       = 0;
                m_l       = (SKIP && (a == 8'd0 || b == 8'd0)) ? 0 : 4;
                acc_flag  = 1'b1;
                since_acc = -1;
                lat_obs   = -1;
                mul_log.delete();
                acc_q.push_back(cyc);
                $display("accept  cycle %0d a=0x%02h b=0x%02h", cyc, a, b);
            end
        end else if (m_n >= m_l) begin
            if (out_ready) begin
                m_busy = 1'b0;
                m_ret  = {8'd0, m_a} * {8'd0, m_b};
                hs_q.push_back(product);
                $display("result  cycle %0d a=0x%02h b=0x%02h product=0x%04h", cyc, m_a, m_b, product);
            end
        end else begin
            m_n++;
        end
    endfunction

    // One clock: check at the falling edge, change inputs 2 after the rise.
    task automatic step();
        @(negedge clk);
        cmp_adv();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Single operation: offer, wait for result, stall `hold` cycles, handshake.
    task automatic op(input logic [7:0] x, input logic [7:0] y, input int hold,
                      input logic [15:0] exp, input int exp_lat, input string nm);
        int k;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0; acc_flag = 1'b0;
        k = 0;
        while (!acc_flag && k < 20) begin step(); k++; end
        chk({nm, "_accepted"}, 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        k = 0;
        while (lat_obs < 0 && k < 20) begin step(); k++; end
        chk({nm, "_latency"}, 32'(lat_obs), 32'(exp_lat));
        chk({nm, "_product"}, 32'(product), 32'(exp));
        repeat (hold) step();
        chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, "_hold_out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_hold_product"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, "_post_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_retained"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int k;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        step();
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Worked example with pinned nibble sequence.
        op(8'h12, 8'h34, 0, 16'h03A8, LAT_FULL, "ex12x34");
        chk("ex12x34_passes", 32'(mul_log.size()), 32'd4);
        if (mul_log.size() == 4) begin
            chk("ex12x34_pass0", 32'(mul_log[0]), 32'h24);
            chk("ex12x34_pass1", 32'(mul_log[1]), 32'h14);
            chk("ex12x34_pass2", 32'(mul_log[2]), 32'h23);
            chk("ex12x34_pass3", 32'(mul_log[3]), 32'h13);
        end

        op(8'hFF, 8'hFF, 0, 16'hFE01, LAT_FULL, "max");
        op(8'h0F, 8'hF0, 10, 16'h0E10, LAT_FULL, "stall");

        // Abort after three passes.
        a = 8'hAB; b = 8'hCD; in_valid = 1'b1; acc_flag = 1'b0;
        k = 0;
        while (!acc_flag && k < 20) begin step(); k++; end
        chk("abort_accepted", 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        op(8'h03, 8'h05, 0, 16'h000F, LAT_FULL, "after_abort");

        op(8'h00, 8'h77, 0, 16'h0000, LAT_ZERO, "zero");
        chk("zero_passes", 32'(mul_log.size()), SKIP ? 32'd0 : 32'd4);

        // Back-to-back offers with the consumer always ready.
        acc_q.delete();
        hs_q.delete();
        a = 8'h10; b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        while (acc_q.size() < 1 && k < 20) begin step(); k++; end
        a = 8'h02; b = 8'h80;
        k = 0;
        while (acc_q.size() < 2 && k < 20) begin step(); k++; end
        in_valid = 1'b0;
        k = 0;
        while (hs_q.size() < 2 && k < 20) begin step(); k++; end
        out_ready = 1'b0;
        chk("b2b_results", 32'(hs_q.size()), 32'd2);
        if (acc_q.size() >= 2) chk("b2b_interval", 32'(acc_q[1] - acc_q[0]), 32'd6);
        else chk("b2b_second_accept", 32'(acc_q.size()), 32'd2);
        if (hs_q.size() >= 2) begin
            chk("b2b_first", 32'(hs_q[0]), 32'h0100);
            chk("b2b_second", 32'(hs_q[1]), 32'h0100);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 3) != 0;
            a         = (($urandom % 6) == 0) ? 8'd0 : 8'($urandom);
            b         = (($urandom % 6) == 0) ? 8'd0 : 8'($urandom);
            out_ready = ($urandom % 2) == 1;
            rst_n     = ($urandom % 90) != 0;
            step();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
